// File: rtl/mantissa_div_seq_if.sv
// rtl/mantissa_div_seq_if.sv - operand/result handshake bundle for the iterative mantissa divider
interface mantissa_div_seq_if #(
  parameter int WIDTH = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   quotient;
  logic [WIDTH:0]   remainder;
  logic             sticky;
  logic             div_zero;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, quotient, remainder, sticky, div_zero, ovf, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, quotient, remainder, sticky, div_zero, ovf, busy
  );
endinterface

// File: rtl/mantissa_div_seq.sv
// rtl/mantissa_div_seq.sv - restoring mantissa divider, one quotient bit per clock, MSB first
module mantissa_div_seq #(
  parameter int WIDTH = 24
) (
  input logic               clk,
  input logic               rst_n,
  input logic               flush,
  mantissa_div_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH:0]   div_r;
  logic [WIDTH-1:0] q_r;
  logic [CW-1:0]    cnt;
  logic             ovf_r;

  logic [WIDTH:0]   step_t;
  logic [WIDTH:0]   step_diff;
  logic [WIDTH:0]   rem_nx;
  logic             step_ge;
  logic             acc_ovf;

  // The first step compares the unshifted dividend so the integer quotient bit comes out first.
  always_comb begin
    step_t    = (cnt == CNT_TOP) ? rem_r : {rem_r[WIDTH-1:0], 1'b0};
    step_ge   = (step_t >= div_r);
    step_diff = step_t - div_r;
    rem_nx    = step_ge ? step_diff : step_t;
    acc_ovf   = ({1'b0, bus.in_a} >= {bus.in_b, 1'b0});
  end

  assign bus.in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rem_r         <= '0;
      div_r         <= '0;
      q_r           <= '0;
      cnt           <= '0;
      ovf_r         <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.sticky    <= 1'b0;
      bus.div_zero  <= 1'b0;
      bus.ovf       <= 1'b0;
    end else if (flush) begin
      state         <= IDLE;
      q_r           <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.sticky    <= 1'b0;
      bus.div_zero  <= 1'b0;
      bus.ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            rem_r <= {1'b0, bus.in_a};
            div_r <= {1'b0, bus.in_b};
            q_r   <= '0;
            cnt   <= CNT_TOP;
            ovf_r <= acc_ovf;
            if (bus.in_b == '0) begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.quotient  <= '1;
              bus.remainder <= {1'b0, bus.in_a};
              bus.sticky    <= |bus.in_a;
              bus.div_zero  <= 1'b1;
              bus.ovf       <= acc_ovf;
            end else begin
              state    <= RUN;
              bus.busy <= 1'b1;
            end
          end
        end
        RUN: begin
          rem_r <= rem_nx;
          q_r   <= {q_r[WIDTH-2:0], step_ge};
          // Results are published only here so partial quotients never reach the outputs.
          if (cnt == '0) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.quotient  <= {q_r, step_ge};
            bus.remainder <= rem_nx;
            bus.sticky    <= |rem_nx;
            bus.div_zero  <= 1'b0;
            bus.ovf       <= ovf_r;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mantissa_div_seq.sv
// tb/tb_mantissa_div_seq.sv - randomized scoreboard bench for mantissa_div_seq
module tb_mantissa_div_seq;
  localparam int W = 24;

  logic clk;
  logic rst_n;
  logic flush;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rdy_mode = 0;

  typedef struct {
    logic [W:0] q;
    logic [W:0] r;
    logic       sticky;
    logic       dz;
    logic       ovf;
    logic       qr_valid;
  } exp_t;

  exp_t sb[$];

  mantissa_div_seq_if #(.WIDTH(W)) bus ();

  mantissa_div_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Quotient/remainder straight from the arithmetic definition of the division.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint unsigned num, q, r;
    e.dz       = (b == 0);
    e.ovf      = (64'(a) >= 2 * 64'(b));
    e.qr_valid = 1'b1;
    if (e.dz) begin
      e.q      = {(W+1){1'b1}};
      e.r      = {1'b0, a};
      e.sticky = (a != 0);
    end else if (e.ovf) begin
      e.qr_valid = 1'b0;
      e.q = '0;
      e.r = '0;
      e.sticky = 1'b0;
    end else begin
      num = 64'(a) << W;
      q   = num / 64'(b);
      r   = num - q * 64'(b);
      e.q = q[W:0];
      e.r = r[W:0];
      e.sticky = (r != 0);
    end
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int t = 0;
    while (!bus.in_ready && t < 200) begin
      step(1);
      t++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    sb.push_back(model(a, b));
    step(1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || !bus.in_ready) && t < 500) begin
      step(1);
      t++;
    end
    if (t >= 500) chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_ov();
    int t = 0;
    while (!bus.out_valid && t < 100) begin
      step(1);
      t++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_quotient"}, bus.quotient, 0);
    chk({tag, "_remainder"}, bus.remainder, 0);
    chk({tag, "_sticky"}, bus.sticky, 0);
    chk({tag, "_div_zero"}, bus.div_zero, 0);
    chk({tag, "_ovf"}, bus.ovf, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.out_ready = ($urandom_range(0, 3) != 0);
        1: bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: latency/busy bookkeeping and scoreboard comparison on every result transfer.
  initial begin
    logic prev_ov = 1'b0;
    int   acc_cyc = 0;
    int   busy_n = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n || flush) begin
        prev_ov = 1'b0;
        continue;
      end
      if (bus.busy) busy_n++;
      if (bus.in_valid && bus.in_ready) begin
        acc_cyc = cyc + 1;
        busy_n = 0;
      end
      if (bus.out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else if (sb[0].dz) begin
          chk("latency_div_zero", ((cyc - acc_cyc) <= 1), 1);
          chk("busy_cycles_div_zero", busy_n, 0);
        end else begin
          chk("latency", cyc - acc_cyc, W + 1);
          chk("busy_cycles", busy_n, W + 1);
        end
      end
      prev_ov = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("result_without_request", 1, 0);
        end else begin
          e = sb.pop_front();
          if (e.qr_valid) begin
            chk("quotient", bus.quotient, e.q);
            chk("remainder", bus.remainder, e.r);
            chk("sticky", bus.sticky, e.sticky);
          end
          chk("div_zero", bus.div_zero, e.dz);
          chk("ovf", bus.ovf, e.ovf);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] a, b;
    exp_t         e;
    logic [W-1:0] dir_a[5] = '{24'h800000, 24'hC00000, 24'h800000, 24'h900000, 24'h000003};
    logic [W-1:0] dir_b[5] = '{24'h800000, 24'h800000, 24'hC00000, 24'h000000, 24'h000001};

    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
    #1;
    check_zero_outputs("reset");
    step(3);
    rst_n = 1'b1;
    step(1);

    for (int i = 0; i < 5; i++) do_op(dir_a[i], dir_b[i]);
    wait_drain();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: begin a = W'($urandom); b = '0; end
        1: begin a = W'($urandom); b = W'($urandom); end
        default: begin a = W'($urandom) | 24'h800000; b = W'($urandom) | 24'h800000; end
      endcase
      do_op(a, b);
    end
    wait_drain();

    // Backpressure: result held, in_valid ignored while DONE.
    rdy_mode = 1;
    e = model(24'hA00000, 24'h900000);
    do_op(24'hA00000, 24'h900000);
    wait_ov();
    bus.in_valid = 1'b1;
    bus.in_a = 24'h812345;
    bus.in_b = 24'hFFFFFF;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("hold_quotient", bus.quotient, e.q);
      chk("hold_remainder", bus.remainder, e.r);
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    rdy_mode = 0;
    wait_drain();

    // Asynchronous reset during RUN.
    do_op(24'hF00000, 24'h812345);
    step(10);
    sb.delete();
    rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_mid_run");
    step(2);
    rst_n = 1'b1;
    do_op(24'hABCDEF, 24'hC12345);
    wait_drain();

    // Flush during RUN.
    do_op(24'hFFFFFF, 24'h800001);
    step(5);
    sb.delete();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_run_in_ready", bus.in_ready, 1);
    chk("flush_run_out_valid", bus.out_valid, 0);
    chk("flush_run_busy", bus.busy, 0);

    // Flush and out_ready together in DONE.
    rdy_mode = 1;
    do_op(24'hC00000, 24'h800000);
    wait_ov();
    sb.delete();
    #1;
    flush = 1'b1;
    bus.out_ready = 1'b1;
    rdy_mode = 2;
    step(1);
    flush = 1'b0;
    chk("flush_done_out_valid", bus.out_valid, 0);
    chk("flush_done_quotient", bus.quotient, 0);
    chk("flush_done_in_ready", bus.in_ready, 1);

    rdy_mode = 0;
    for (int i = 0; i < 6; i++) do_op(W'($urandom) | 24'h800000, W'($urandom) | 24'h800000);
    wait_drain();
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
